action_dispatch: RTL and testbench
==================================

# action_dispatch

Buffers per-thread action words from the packet classifier and delivers them to the register file's action-write port. The register file gives its normal write port (`wena`) priority and silently drops an action that coincides with it, so this block holds each action until the write port is idle. It sits directly upstream of the register file's `action_data_in` / `action_wen` / `action_thread_id_in` inputs. It also screens out thread IDs the register file does not map.

## Interface
Parameters:
- NUM_ACTIONS, 8, width of one action word
- THREAD_BITS, 2, width of thread ID
- DEPTH_BITS, 2, log2 of queue depth (default depth 4)
- STARVE_LIMIT, 16, consecutive blocked cycles before `starve_out` asserts; legal range 1..255

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- act_valid_in  in  1  classifier offers an action
- act_data_in  in  NUM_ACTIONS  action word
- act_thread_in  in  THREAD_BITS  target thread
- act_ready_out  out  1  queue can accept; equals !full
- wb_wena_in  in  1  same signal that drives the register file `wena`
- action_data_out  out  NUM_ACTIONS  head action word, to the register file `action_data_in`
- action_wen_out  out  1  to the register file `action_wen`
- action_thread_id_out  out  THREAD_BITS  head thread ID, to the register file `action_thread_id_in`
- count_out  out  DEPTH_BITS+1  entries currently queued
- err_thread_out  out  1  sticky: an action with an invalid thread ID was rejected
- starve_out  out  1  head has been blocked for STARVE_LIMIT or more consecutive cycles

## Operation
Queue:
- First-word-fall-through circular FIFO of {thread, data}, 2^DEPTH_BITS entries.
- Write pointer, read pointer and count registers.
- Pointers wrap modulo depth.

Enqueue:
- Occurs on a rising edge when act_valid_in && act_ready_out.
- Only thread IDs 0 and 1 are stored.
- An ID ≥ 2 is consumed but not stored: the handshake completes, count is unchanged, and err_thread_out is set.
- err_thread_out is cleared only by reset.

Issue:
- action_wen_out = (count != 0) && !wb_wena_in. This path is combinational.
- action_data_out and action_thread_id_out always show the head entry, or 0 when the queue is empty.
- A pop occurs on the edge where action_wen_out is 1.

Simultaneous events:
- Push and pop in the same cycle: count unchanged, both pointers advance.
- act_ready_out depends only on the current full state. When full, no enqueue is accepted even if a pop occurs that cycle.

Starvation counter:
- 8-bit, saturating.
- Increments each cycle where count != 0 && wb_wena_in.
- Clears on any cycle with count == 0 or !wb_wena_in.
- starve_out = (counter >= STARVE_LIMIT). Indication only; it does not change issue behaviour.

Reset, at any time including mid-transfer:
- Pointers, count, err flag and starve counter go to 0.
- Queued entries are discarded.

## Timing
Reset values:
- act_ready_out = 1
- action_wen_out = 0
- action_data_out = 0
- action_thread_id_out = 0
- count_out = 0
- err_thread_out = 0
- starve_out = 0

Latency:
- An action accepted at edge N can appear with action_wen_out = 1 in cycle N+1, provided wb_wena_in is low.
- Minimum latency is 1 cycle; throughput is 1 action per cycle.

Blocking:
- wb_wena_in high forces action_wen_out low in the same cycle, so there is no overlap with the register-file write.

Output timing:
- count_out and err_thread_out are registered.
- starve_out is registered: it asserts on the edge where the counter reaches STARVE_LIMIT.
- Release of reset is synchronised externally. The block only requires the asynchronous assertion.

## Test plan
- **Reset:** hold reset and drive act_valid_in=1. Require act_ready_out=1, count_out=0, action_wen_out=0, with no enqueue while reset is high.
- **Single action, idle port:** enqueue {thread 1, data 8'hA5} with wb_wena_in=0. Next cycle: action_wen_out=1, action_data_out=8'hA5, action_thread_id_out=1. The following cycle count_out=0.
- **Blocked issue:** enqueue 3 actions while wb_wena_in=1 for 20 cycles. Require:
  - action_wen_out=0 throughout;
  - starve_out=1 from blocked cycle 16;
  - after wb_wena_in drops, the 3 actions issue in order on 3 consecutive cycles;
  - starve_out returns to 0.
- **Full / wrap:**
  - Fill 4 entries; act_ready_out=0 and count_out=4.
  - Offer a 5th action with simultaneous pop. The offer is not accepted; count_out=3.
  - Stream 10 more actions at one per cycle. All issue in order and the pointers wrap correctly.
- **Invalid thread:** enqueue thread 2, data 8'hFF. Require the handshake to complete, count_out to stay 0, no action_wen_out, and err_thread_out=1 until reset.
- **Reset mid-operation:** with 3 entries queued, assert reset asynchronously between edges. Outputs clear immediately, and no actions issue after reset deasserts.

Source files
------------

// File: rtl/action_dispatch.sv
// Holds classifier actions in a small FWFT queue and issues each one to the
// register file's action-write port only on cycles where its normal write port is idle.
module action_dispatch #(
  parameter int NUM_ACTIONS  = 8,
  parameter int THREAD_BITS  = 2,
  parameter int DEPTH_BITS   = 2,
  parameter int STARVE_LIMIT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   act_valid_in,
  input  logic [NUM_ACTIONS-1:0] act_data_in,
  input  logic [THREAD_BITS-1:0] act_thread_in,
  output logic                   act_ready_out,
  input  logic                   wb_wena_in,
  output logic [NUM_ACTIONS-1:0] action_data_out,
  output logic                   action_wen_out,
  output logic [THREAD_BITS-1:0] action_thread_id_out,
  output logic [DEPTH_BITS:0]    count_out,
  output logic                   err_thread_out,
  output logic                   starve_out
);

  localparam int            DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] FULL_CNT = {1'b1, {DEPTH_BITS{1'b0}}};
  localparam logic [7:0]    STARVE_LIM8 = STARVE_LIMIT[7:0];

  logic [NUM_ACTIONS-1:0] data_mem [DEPTH];
  logic [THREAD_BITS-1:0] thr_mem  [DEPTH];
  logic [DEPTH_BITS-1:0]  wr_ptr, rd_ptr;
  logic [DEPTH_BITS:0]    count;
  logic [7:0]             starve_cnt, starve_nxt;
  logic                   full, empty, accept, thread_ok, push, pop, blocked;

  assign full      = (count == FULL_CNT);
  assign empty     = (count == '0);
  assign thread_ok = ((act_thread_in >> 1) == '0);
  assign accept    = act_valid_in && !full;
  assign push      = accept && thread_ok;
  assign pop       = !empty && !wb_wena_in;
  assign blocked   = !empty && wb_wena_in;

  assign act_ready_out        = !full;
  assign action_wen_out       = pop;
  assign action_data_out      = empty ? '0 : data_mem[rd_ptr];
  assign action_thread_id_out = empty ? '0 : thr_mem[rd_ptr];
  assign count_out            = count;

  // Storage is not reset: an empty queue masks the head to zero.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= act_data_in;
      thr_mem[wr_ptr]  <= act_thread_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Bad thread IDs still complete the handshake so the classifier never stalls on them.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    err_thread_out <= 1'b0;
    else if (accept && !thread_ok) err_thread_out <= 1'b1;
  end

  always_comb begin
    starve_nxt = '0;
    if (blocked) starve_nxt = (starve_cnt == 8'hFF) ? starve_cnt : starve_cnt + 8'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      starve_cnt <= '0;
      starve_out <= 1'b0;
    end else begin
      starve_cnt <= starve_nxt;
      starve_out <= (starve_nxt >= STARVE_LIM8);
    end
  end

endmodule

// File: tb/tb_action_dispatch.sv
// Randomized + directed bench for action_dispatch, checked every cycle against a queue model.
module tb_action_dispatch;
  localparam int LIMIT = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       act_valid_in = 1'b0;
  logic [7:0] act_data_in = '0;
  logic [1:0] act_thread_in = '0;
  logic       wb_wena_in = 1'b0;
  logic       act_ready_out, action_wen_out, err_thread_out, starve_out;
  logic [7:0] action_data_out;
  logic [1:0] action_thread_id_out;
  logic [2:0] count_out;

  action_dispatch #(.NUM_ACTIONS(8), .THREAD_BITS(2), .DEPTH_BITS(2), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .act_valid_in(act_valid_in), .act_data_in(act_data_in), .act_thread_in(act_thread_in),
    .act_ready_out(act_ready_out), .wb_wena_in(wb_wena_in),
    .action_data_out(action_data_out), .action_wen_out(action_wen_out),
    .action_thread_id_out(action_thread_id_out), .count_out(count_out),
    .err_thread_out(err_thread_out), .starve_out(starve_out)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a plain queue plus a run-length of blocked cycles.
  typedef struct { logic [1:0] t; logic [7:0] d; } entry_t;
  entry_t m_q[$];
  bit     m_err = 0;
  int     m_blk = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q.delete();
      m_err = 0;
      m_blk = 0;
    end else begin
      bit acc, pop;
      acc = act_valid_in && (m_q.size() < 4);
      pop = (m_q.size() != 0) && !wb_wena_in;
      m_blk = ((m_q.size() != 0) && wb_wena_in) ? ((m_blk < 255) ? m_blk + 1 : 255) : 0;
      if (pop) void'(m_q.pop_front());
      if (acc && act_thread_in < 2) m_q.push_back('{t: act_thread_in, d: act_data_in});
      if (acc && act_thread_in >= 2) m_err = 1;
    end
  end

  always @(negedge clk) begin
    bit ne;
    ne = (m_q.size() != 0);
    chk("ready", act_ready_out, m_q.size() < 4);
    chk("count", count_out, m_q.size());
    chk("wen",   action_wen_out, ne && !wb_wena_in);
    chk("data",  action_data_out, ne ? m_q[0].d : 8'h00);
    chk("thread", action_thread_id_out, ne ? m_q[0].t : 2'd0);
    chk("err",   err_thread_out, m_err);
    chk("starve", starve_out, m_blk >= LIMIT);
  end

  // Inputs change 1 time unit after the edge; literal checks follow 1 unit later.
  task automatic cyc(input logic v, input logic [7:0] d, input logic [1:0] t, input logic w);
    @(posedge clk);
    #1;
    act_valid_in = v; act_data_in = d; act_thread_in = t; wb_wena_in = w;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    #2 reset = 1'b1;
    // Reset held with an offered action
    repeat (2) begin
      cyc(1, 8'h77, 2'd1, 0);
      chk("rst_ready", act_ready_out, 1);
      chk("rst_count", count_out, 0);
      chk("rst_wen", action_wen_out, 0);
    end
    cyc(0, 0, 0, 0);
    reset = 1'b0;

    // Single action on idle port
    cyc(1, 8'hA5, 2'd1, 0);
    cyc(0, 0, 0, 0);
    chk("single_wen", action_wen_out, 1);
    chk("single_data", action_data_out, 8'hA5);
    chk("single_thr", action_thread_id_out, 1);
    cyc(0, 0, 0, 0);
    chk("single_cnt", count_out, 0);

    // Blocked issue for 20 cycles
    cyc(1, 8'h11, 2'd0, 1);
    cyc(1, 8'h22, 2'd1, 1);
    cyc(1, 8'h33, 2'd0, 1);
    repeat (17) cyc(0, 0, 0, 1);
    chk("blk_starve", starve_out, 1);
    chk("blk_wen", action_wen_out, 0);
    cyc(0, 0, 0, 0);
    chk("blk_d0", action_data_out, 8'h11);
    chk("blk_w0", action_wen_out, 1);
    cyc(0, 0, 0, 0);
    chk("blk_d1", action_data_out, 8'h22);
    cyc(0, 0, 0, 0);
    chk("blk_d2", action_data_out, 8'h33);
    cyc(0, 0, 0, 0);
    chk("blk_starve_clr", starve_out, 0);
    chk("blk_empty", count_out, 0);

    // Full, rejected offer during pop, then streaming through the wrap
    for (int i = 0; i < 4; i++) cyc(1, 8'hC0 + 8'(i), 2'(i % 2), 1);
    cyc(0, 0, 0, 1);
    chk("full_ready", act_ready_out, 0);
    chk("full_cnt", count_out, 4);
    cyc(1, 8'h55, 2'd0, 0);
    chk("full_ready2", act_ready_out, 0);
    for (int i = 0; i < 10; i++) begin
      cyc(1, 8'h60 + 8'(i), 2'(i % 2), 0);
      if (i == 0) chk("full_pop_cnt", count_out, 3);
    end
    repeat (5) cyc(0, 0, 0, 0);

    // Invalid thread
    cyc(1, 8'hFF, 2'd2, 0);
    chk("inv_ready", act_ready_out, 1);
    cyc(0, 0, 0, 0);
    chk("inv_cnt", count_out, 0);
    chk("inv_err", err_thread_out, 1);
    chk("inv_wen", action_wen_out, 0);
    repeat (3) cyc(0, 0, 0, 0);
    chk("inv_sticky", err_thread_out, 1);

    // Asynchronous reset with 3 entries queued
    for (int i = 0; i < 3; i++) cyc(1, 8'h90 + 8'(i), 2'd1, 1);
    cyc(0, 0, 0, 1);
    wb_wena_in = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("mid_cnt", count_out, 0);
    chk("mid_wen", action_wen_out, 0);
    chk("mid_data", action_data_out, 0);
    chk("mid_err", err_thread_out, 0);
    cyc(1, 8'hEE, 2'd0, 0);
    cyc(1, 8'hEF, 2'd1, 0);
    cyc(0, 0, 0, 0);
    reset = 1'b0;
    repeat (4) begin
      cyc(0, 0, 0, 0);
      chk("post_rst_wen", action_wen_out, 0);
    end

    // Random traffic, including long blocked stretches
    for (int i = 0; i < 600; i++) begin
      logic [1:0] t;
      logic       w;
      t = ($urandom_range(0, 7) == 0) ? 2'(2 + $urandom_range(0, 1)) : 2'($urandom_range(0, 1));
      w = ((i / 40) % 3 == 1) ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 3) == 0);
      cyc(1'($urandom_range(0, 1)), 8'($urandom), t, w);
      if (i == 300) begin
        #1 reset = 1'b1;
        cyc(0, 0, 0, 0);
        reset = 1'b0;
      end
    end
    repeat (6) cyc(0, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
